// File: rtl/step_controller.sv
// Debug single-step controller: conditions the step/run buttons, queues step
// presses and issues one-instruction execute requests to the core.

module step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic press_out
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level follows the synchronized input only after a full run of mismatching cycles
  always_comb begin
    sync1_d      = btn_in;
    sync2_d      = sync1_q;
    level_d      = level_q;
    level_prev_d = level_q;
    cnt_d        = '0;
    press_d      = level_q & ~level_prev_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press_out = press_q;

endmodule

module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PENDING_MAX     = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        step_btn_in,
  input  logic        run_btn_in,
  output logic        step_valid_out,
  input  logic        step_ready_in,
  input  logic        instr_done_in,
  output logic        run_mode_out,
  output logic        busy_out,
  output logic [2:0]  pending_out,
  output logic [15:0] step_count_out
);

  localparam int unsigned PEND_W  = 3;
  localparam int unsigned COUNT_W = 16;
  localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(PENDING_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

  logic step_press;
  logic run_press;

  state_e               state_q, state_d;
  logic                 run_mode_q, run_mode_d;
  logic [PEND_W-1:0]    pending_q, pending_d;
  logic [COUNT_W-1:0]   step_count_q, step_count_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic step_inc;
  logic accept;
  logic step_dec;

  step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn_in    (step_btn_in),
    .press_out (step_press)
  );

  step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .btn_in    (run_btn_in),
    .press_out (run_press)
  );

  // Presses only queue in single-step mode; a run-mode acceptance never dequeues
  assign step_inc = step_press & ~run_mode_q;
  assign accept   = (state_q == ST_REQ) & step_ready_in;
  assign step_dec = accept & ~run_mode_q & (pending_q != '0);

  always_comb begin
    state_d      = state_q;
    run_mode_d   = run_mode_q ^ run_press;
    pending_d    = pending_q;
    step_count_d = step_count_q;

    case (state_q)
      ST_IDLE: begin
        if (run_mode_q || (pending_q != '0)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (step_ready_in) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (instr_done_in) begin
          state_d      = ST_IDLE;
          step_count_d = step_count_q + COUNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Simultaneous press and dequeue cancel, including at saturation
    if (step_inc && !step_dec) begin
      if (pending_q != PEND_LIMIT) begin
        pending_d = pending_q + PEND_W'(1);
      end
    end else if (step_dec && !step_inc) begin
      pending_d = pending_q - PEND_W'(1);
    end

    valid_d = (state_d == ST_REQ);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      run_mode_q   <= 1'b0;
      pending_q    <= '0;
      step_count_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_mode_q   <= run_mode_d;
      pending_q    <= pending_d;
      step_count_q <= step_count_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign step_valid_out = valid_q;
  assign run_mode_out   = run_mode_q;
  assign busy_out       = busy_q;
  assign pending_out    = pending_q;
  assign step_count_out = step_count_q;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: scoreboard of expected completion counts
// plus a small model of the step queue and run mode.

module tb_step_controller;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, step_btn, run_btn, step_ready, instr_done;
  logic        step_valid, run_mode, busy;
  logic [2:0]  pending;
  logic [15:0] step_count;

  logic        db_step_btn, db_run_btn, db_ready, db_done;
  logic        db_valid, db_run, db_busy;
  logic [2:0]  db_pending;
  logic [15:0] db_count;

  step_controller #(.DEBOUNCE_CYCLES(1), .PENDING_MAX(7)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .step_btn_in    (step_btn),
    .run_btn_in     (run_btn),
    .step_valid_out (step_valid),
    .step_ready_in  (step_ready),
    .instr_done_in  (instr_done),
    .run_mode_out   (run_mode),
    .busy_out       (busy),
    .pending_out    (pending),
    .step_count_out (step_count)
  );

  step_controller #(.DEBOUNCE_CYCLES(4), .PENDING_MAX(7)) dut_db (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .step_btn_in    (db_step_btn),
    .run_btn_in     (db_run_btn),
    .step_valid_out (db_valid),
    .step_ready_in  (db_ready),
    .instr_done_in  (db_done),
    .run_mode_out   (db_run),
    .busy_out       (db_busy),
    .pending_out    (db_pending),
    .step_count_out (db_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];
  int sb_last  = 0;
  int model_pending = 0;
  bit model_run = 1'b0;
  int n_acc;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    sb_last++;
    sb_q.push_back(sb_last);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    sb_q.delete();
    sb_last = 0;
    model_pending = 0;
    model_run = 1'b0;
  endtask

  task automatic press_step(input bit hold);
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    repeat (6) begin
      tick();
      if (hold) chk("valid_hold_step", 32'(step_valid), 1);
    end
    if (!model_run && model_pending < 7) begin
      model_pending++;
      push_exp();
    end
    chk("pending_after_press", 32'(pending), 32'(model_pending));
  endtask

  task automatic press_run(input bit hold);
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
    repeat (6) begin
      tick();
      if (hold) chk("valid_hold_run", 32'(step_valid), 1);
    end
    model_run = !model_run;
    chk("run_mode", 32'(run_mode), 32'(model_run));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (step_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(step_valid), 1);
  endtask

  task automatic accept();
    step_ready = 1'b1;
    tick();
    step_ready = 1'b0;
    if (!model_run && model_pending > 0) model_pending--;
    chk("accept_valid_low", 32'(step_valid), 0);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_pending", 32'(pending), 32'(model_pending));
  endtask

  task automatic complete();
    int exp;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 1);
    end else begin
      exp = sb_q.pop_front();
      chk("step_count", 32'(step_count), 32'(exp));
    end
    chk("done_busy_low", 32'(busy), 0);
  endtask

  initial begin
    rst_in = 1'b1;
    step_btn = 1'b0; run_btn = 1'b0; step_ready = 1'b0; instr_done = 1'b0;
    db_step_btn = 1'b0; db_run_btn = 1'b0; db_ready = 1'b0; db_done = 1'b0;
    repeat (3) tick();
    rst_in = 1'b0;

    chk("rst_valid", 32'(step_valid), 0);
    chk("rst_run", 32'(run_mode), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_count", 32'(step_count), 0);
    chk("rst_db_valid", 32'(db_valid), 0);
    chk("rst_db_run", 32'(db_run), 0);
    chk("rst_db_busy", 32'(db_busy), 0);
    chk("rst_db_pending", 32'(db_pending), 0);
    chk("rst_db_count", 32'(db_count), 0);

    // Debounce: short glitch rejected, long press counted once
    db_step_btn = 1'b1;
    repeat (3) tick();
    db_step_btn = 1'b0;
    repeat (12) tick();
    chk("db_short_pending", 32'(db_pending), 0);
    chk("db_short_valid", 32'(db_valid), 0);
    db_step_btn = 1'b1;
    repeat (6) tick();
    db_step_btn = 1'b0;
    repeat (14) tick();
    chk("db_long_pending", 32'(db_pending), 1);
    chk("db_long_valid", 32'(db_valid), 1);

    // Single step with exact latency
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick(); tick(); tick();
    chk("ss_pending_t3", 32'(pending), 0);
    chk("ss_valid_t3", 32'(step_valid), 0);
    tick();
    chk("ss_pending_t4", 32'(pending), 1);
    chk("ss_valid_t4", 32'(step_valid), 0);
    tick();
    chk("ss_valid_t5", 32'(step_valid), 1);
    chk("ss_busy_t5", 32'(busy), 1);
    model_pending = 1;
    push_exp();
    n_acc = 1;
    accept();
    step_ready = 1'b1;
    complete();
    chk("ss_pending_end", 32'(pending), 0);
    repeat (5) begin
      if (step_valid === 1'b1 && step_ready === 1'b1) n_acc++;
      tick();
    end
    step_ready = 1'b0;
    chk("ss_one_accept", 32'(n_acc), 1);
    chk("ss_idle_busy", 32'(busy), 0);

    // Saturation: 9 presses with ready low
    do_reset();
    press_step(1'b0);
    chk("sat_valid_first", 32'(step_valid), 1);
    for (int i = 1; i < 9; i++) press_step(1'b1);
    chk("sat_pending", 32'(pending), 7);
    for (int i = 0; i < 7; i++) begin
      wait_valid();
      accept();
      complete();
    end
    chk("sat_count", 32'(step_count), 7);
    repeat (10) begin
      tick();
      chk("sat_idle_valid", 32'(step_valid), 0);
      chk("sat_idle_busy", 32'(busy), 0);
    end

    // Saturated queue: press coinciding with a dequeue stays at the limit
    for (int i = 0; i < 7; i++) press_step(1'b0);
    chk("satc_valid", 32'(step_valid), 1);
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick(); tick(); tick();
    step_ready = 1'b1;
    tick();
    step_ready = 1'b0;
    chk("satc_pending", 32'(pending), 7);
    chk("satc_valid_low", 32'(step_valid), 0);

    // Handshake hold across two run toggles, then coincident press/dequeue
    do_reset();
    press_step(1'b0);
    press_step(1'b1);
    chk("hs_valid", 32'(step_valid), 1);
    repeat (2) begin
      tick();
      chk("hs_valid_hold", 32'(step_valid), 1);
    end
    press_run(1'b1);
    press_run(1'b1);
    accept();
    chk("hs_pending_dec", 32'(pending), 1);
    complete();
    wait_valid();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick(); tick(); tick();
    step_ready = 1'b1;
    tick();
    step_ready = 1'b0;
    push_exp();
    chk("hs_coincide_pending", 32'(pending), 1);
    chk("hs_coincide_valid", 32'(step_valid), 0);
    complete();
    wait_valid();
    accept();
    complete();
    chk("hs_count", 32'(step_count), 3);

    // Run mode at full rate, stop during EXEC, then reset mid-EXEC
    do_reset();
    press_run(1'b0);
    chk("run_valid", 32'(step_valid), 1);
    press_step(1'b1);
    for (int i = 0; i < 254; i++) begin
      chk("run_valid_rate", 32'(step_valid), 1);
      accept();
      push_exp();
      complete();
      tick();
    end
    chk("run_valid_last", 32'(step_valid), 1);
    accept();
    press_run(1'b0);
    chk("stop_busy", 32'(busy), 1);
    chk("stop_valid", 32'(step_valid), 0);
    push_exp();
    complete();
    chk("stop_count", 32'(step_count), 32'h00FF);
    repeat (10) begin
      tick();
      chk("stop_idle_valid", 32'(step_valid), 0);
    end
    for (int i = 0; i < 4; i++) press_step(1'b0);
    accept();
    chk("rx_pending", 32'(pending), 3);
    chk("rx_count", 32'(step_count), 32'h00FF);
    do_reset();
    chk("rx_valid", 32'(step_valid), 0);
    chk("rx_run", 32'(run_mode), 0);
    chk("rx_busy", 32'(busy), 0);
    chk("rx_pending0", 32'(pending), 0);
    chk("rx_count0", 32'(step_count), 0);
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    tick();
    chk("rx_done_ignored", 32'(step_count), 0);
    chk("rx_idle_valid", 32'(step_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
